// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Read-side consumer for a byte FIFO. Pops DATA_WIDTH-bit entries through
//   the FIFO r_en/empty port and packs PACK consecutive entries into one
//   output word (first-popped entry in the lowest lane). A single-cycle
//   flush request emits whatever partial word is being assembled.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-low reset (shared with the FIFO)
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO data_out, valid the cycle after a fifo_r_en cycle
//   fifo_r_en   FIFO read enable, one entry popped per cycle high
//   flush       single-cycle request to emit a partial word
//   m_data      packed output word
//   m_keep      lane-valid mask, bit i covers lane i
//   m_valid     output word valid
//   m_ready     sink ready
//
// Output handshake: a word transfers on a rising edge where m_valid and
// m_ready are both high. While m_valid is high and m_ready low, m_data and
// m_keep hold steady; m_valid never drops without a transfer. m_valid does
// not depend combinationally on m_ready (it is a flop).
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  output logic                       fifo_r_en,
  input  logic                       flush,
  output logic [PACK*DATA_WIDTH-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output logic                       m_valid,
  input  logic                       m_ready
);

  localparam int WW = PACK * DATA_WIDTH;
  localparam int CW = $clog2(PACK + 1);
  localparam logic [CW:0] PACK_W = (CW + 1)'(PACK);

  logic            inflight_q, inflight_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            flush_pend_q, flush_pend_d;
  logic [WW-1:0]   asm_q, asm_d;
  logic [WW-1:0]   m_data_q, m_data_d;
  logic [PACK-1:0] m_keep_q, m_keep_d;
  logic            m_valid_q, m_valid_d;

  // Lanes occupied once this cycle's in-flight byte (if any) is captured.
  logic [CW:0]     fill;
  logic            out_free;
  logic            load_full;
  logic            load_part;
  logic            flush_done;
  logic [PACK-1:0] part_keep;

  always_comb begin
    out_free = !m_valid_q || m_ready;
    fill     = {1'b0, cnt_q} + (CW + 1)'(inflight_q);

    // Counting the in-flight read against free lanes keeps at most one
    // read outstanding at the tail of a word and stops reads when full.
    fifo_r_en = rst && !fifo_empty && !flush_pend_q && (fill < PACK_W);

    asm_d = asm_q;
    if (inflight_q) begin
      for (int i = 0; i < PACK; i++) begin
        if (cnt_q == CW'(i)) begin
          asm_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
        end
      end
    end

    for (int i = 0; i < PACK; i++) begin
      part_keep[i] = (CW'(i) < cnt_q);
    end

    // fill == PACK covers both a capture landing in the last lane and a
    // word already parked at cnt == PACK waiting for the output register.
    load_full = (fill == PACK_W) && out_free;

    // Flush acts only once nothing is in flight, and never on a full word:
    // a full word always leaves through the normal path first.
    load_part  = flush_pend_q && !inflight_q && (fill < PACK_W) &&
                 (cnt_q != '0) && out_free;
    flush_done = flush_pend_q && !inflight_q && (fill < PACK_W) &&
                 ((cnt_q == '0) || out_free);

    inflight_d = fifo_r_en;
    cnt_d      = fill[CW-1:0];

    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_valid_d = m_valid_q && !m_ready;

    if (load_full) begin
      m_data_d  = asm_d;
      m_keep_d  = '1;
      m_valid_d = 1'b1;
      cnt_d     = '0;
      asm_d     = '0;
    end else if (load_part) begin
      // Unused lanes are already zero because asm is cleared on every load.
      m_data_d  = asm_q;
      m_keep_d  = part_keep;
      m_valid_d = 1'b1;
      cnt_d     = '0;
      asm_d     = '0;
    end

    // A flush arriving while one is pending is absorbed.
    flush_pend_d = flush_pend_q ? !flush_done : flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q   <= 1'b0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      asm_q        <= '0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_valid_q    <= 1'b0;
    end else begin
      inflight_q   <= inflight_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      asm_q        <= asm_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_valid_q    <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Testbench for fifo_word_packer: a byte FIFO model feeds the DUT, a
// byte-level packing model fills an expected-word queue, and a per-cycle
// compare step checks every accepted word, output hold under backpressure,
// reset values and the r_en/empty rule. Directed tests pin the model with
// literal words, latency and the r_en pattern.
module tb_fifo_word_packer;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int W  = DW * PK;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data  = '0;
  logic          fifo_r_en;
  logic          flush   = 1'b0;
  logic [W-1:0]  m_data;
  logic [PK-1:0] m_keep;
  logic          m_valid;
  logic          m_ready = 1'b1;

  logic          wr_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .flush      (flush),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  // ---------------- FIFO model (1-cycle read latency, shared reset) -----
  logic [DW-1:0] fq[$];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fq.delete();
      fifo_data  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_r_en && fq.size() > 0) fifo_data <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0]  exp_q[$];
  logic [PK-1:0] exp_keep_q[$];
  logic [W-1:0]  got_q[$];
  logic [PK-1:0] got_keep_q[$];
  logic [DW-1:0] pend_q[$];

  int           cyc       = 0;
  int           pop_cnt   = 0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [PK-1:0] prev_keep = '0;
  logic         arm       = 1'b0;
  int           first_ren = -1;
  int           first_val = -1;
  logic         rec_en    = 1'b0;
  logic         rec_bits[$];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Packing model: bytes in write order, PK per word, lane 0 first.
  task automatic model_emit();
    logic [W-1:0]  word;
    logic [PK-1:0] keep;
    word = '0;
    keep = '0;
    for (int i = 0; i < pend_q.size(); i++) begin
      word = word | (W'(pend_q[i]) << (DW * i));
      keep[i] = 1'b1;
    end
    exp_q.push_back(word);
    exp_keep_q.push_back(keep);
    pend_q.delete();
  endtask

  task automatic model_push(input logic [DW-1:0] b);
    pend_q.push_back(b);
    if (pend_q.size() == PK) model_emit();
  endtask

  task automatic model_flush();
    if (pend_q.size() > 0) model_emit();
  endtask

  task automatic model_reset();
    pend_q.delete();
    exp_q.delete();
    exp_keep_q.delete();
  endtask

  // Per-cycle compare step, called at the falling edge.
  task automatic sample();
    logic [W-1:0]  e;
    logic [PK-1:0] ek;
    cyc++;
    if (!rst) begin
      check("reset_m_valid", W'(m_valid), '0);
      check("reset_m_data", m_data, '0);
      check("reset_m_keep", W'(m_keep), '0);
      check("reset_r_en", W'(fifo_r_en), '0);
      prev_hold = 1'b0;
    end else begin
      if (fifo_r_en) begin
        pop_cnt++;
        check("r_en_while_empty", W'(fifo_empty), '0);
      end
      if (arm && fifo_r_en && first_ren < 0) first_ren = cyc;
      if (arm && m_valid && first_val < 0) first_val = cyc;
      if (rec_en && (fifo_r_en || rec_bits.size() > 0)) rec_bits.push_back(fifo_r_en);
      if (prev_hold) begin
        check("hold_valid", W'(m_valid), W'(1));
        check("hold_data", m_data, prev_data);
        check("hold_keep", W'(m_keep), W'(prev_keep));
      end
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_keep_q.push_back(m_keep);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", m_data);
        end else begin
          e  = exp_q.pop_front();
          ek = exp_keep_q.pop_front();
          check("sb_data", m_data, e);
          check("sb_keep", W'(m_keep), W'(ek));
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_keep = m_keep;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // at the falling edge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    model_push(b);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_flush();
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    for (int k = 0; k < budget && got_q.size() < n; k++) tick();
    n_checks++;
    if (got_q.size() < n) begin
      n_errors++;
      $display("FAIL %s: got %0d words, expected %0d", name, got_q.size(), n);
    end
  endtask

  function automatic logic [W-1:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return '1;
  endfunction

  function automatic logic [W-1:0] keep_at(input int i);
    if (i < got_keep_q.size()) return W'(got_keep_q[i]);
    return '1;
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int          base;
    logic [9:0]  pat;

    // Reset
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("idle_r_en", W'(fifo_r_en), '0);

    // Single word, first-word latency
    arm = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_words(1, 20, "single_timeout");
    arm = 1'b0;
    check("single_data", got_at(0), 32'h44332211);
    check("single_keep", keep_at(0), 32'hF);
    check("first_word_latency", W'(first_val - first_ren), W'(PK + 1));

    // Streaming and r_en pattern
    rec_en = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    wait_words(3, 20, "stream_timeout");
    rec_en = 1'b0;
    check("stream_word0", got_at(1), 32'h04030201);
    check("stream_word1", got_at(2), 32'h08070605);
    for (int i = 0; i < 10; i++) pat[9-i] = (i < rec_bits.size()) ? rec_bits[i] : 1'b0;
    check("r_en_pattern", W'(pat), W'(10'b1111011110));

    // Partial flush
    push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (4) tick();
    do_flush();
    wait_words(4, 2, "flush_latency");
    check("partial_data", got_at(3), 32'h00CCBBAA);
    check("partial_keep", keep_at(3), 32'h7);
    push(8'hDD); push(8'hEE); push(8'hFF); push(8'h11);
    wait_words(5, 20, "after_flush_timeout");
    check("after_flush_data", got_at(4), 32'h11FFEEDD);
    check("after_flush_keep", keep_at(4), 32'hF);

    // Flush with nothing assembled
    do_flush();
    repeat (6) tick();
    check("empty_flush_words", W'(got_q.size()), W'(5));
    push(8'h21); push(8'h32); push(8'h43); push(8'h54);
    wait_words(6, 20, "resume_timeout");
    check("resume_data", got_at(5), 32'h54433221);

    // Backpressure
    m_ready = 1'b0;
    base = pop_cnt;
    for (int i = 1; i <= 12; i++) push(DW'(i));
    repeat (10) tick();
    check("bp_pop_count", W'(pop_cnt - base), W'(2 * PK));
    check("bp_valid", W'(m_valid), W'(1));
    check("bp_held_data", m_data, 32'h04030201);
    m_ready = 1'b1;
    wait_words(9, 40, "bp_drain_timeout");
    check("bp_word0", got_at(6), 32'h04030201);
    check("bp_word1", got_at(7), 32'h08070605);
    check("bp_word2", got_at(8), 32'h0C0B0A09);

    // Reset with two lanes of a word assembled
    base = pop_cnt;
    push(8'hE1); push(8'hE2);
    for (int k = 0; k < 10 && (pop_cnt - base) < 2; k++) tick();
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    check("async_reset_valid", W'(m_valid), '0);
    check("async_reset_r_en", W'(fifo_r_en), '0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    wait_words(10, 20, "post_reset_timeout");
    check("post_reset_data", got_at(9), 32'h88776655);
    check("post_reset_keep", keep_at(9), 32'hF);

    repeat (4) tick();
    check("sb_drained", W'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
